// File: rtl/mips_pkg.sv
// mips_pkg: instruction-memory geometry and boot-loader state encoding
// shared by the core, the loader and the testbench.
package mips_pkg;
    localparam int IMEM_DEPTH  = 32;
    localparam int IMEM_ADDR_W = 5;
    typedef enum logic [1:0] {LD_IDLE, LD_RECV, LD_WRITE, LD_FINISH} ld_state_e;
endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// byte_word_packer: shifts stream bytes MSB-first into a 32-bit word and
// flags the handshake that delivers the 4th byte of the word.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;
    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = en_i && cnt_q == 2'd3;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (clr_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (en_i) begin
            shift_q <= word_o[23:0];
            cnt_q   <= cnt_q + 2'd1;
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: fills instruction memory from a byte stream and holds the
// core stalled until the whole program is written, then pulses a PC restart.
module imem_boot_loader
    import mips_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_stall,
    output logic              pc_restart,
    output logic              busy,
    output logic              err
);
    ld_state_e         state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d, waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d, word;
    logic              we_q, we_d, stall_q, stall_d, restart_q, restart_d;
    logic              busy_q, busy_d, err_q, err_d, clr, word_valid, len_ok, last;

    assign byte_ready = state_q == LD_RECV;
    assign len_ok     = load_len != '0 && load_len <= (ADDR_W+1)'(DEPTH);
    assign last       = {1'b0, idx_q} + (ADDR_W+1)'(1) == len_q;

    byte_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (clr),
        .en_i         (byte_valid && byte_ready),
        .byte_i       (byte_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        stall_d   = stall_q;
        restart_d = 1'b0;
        err_d     = err_q;
        clr       = 1'b0;
        case (state_q)
            LD_IDLE: if (start) begin
                if (len_ok) begin
                    state_d = LD_RECV;
                    len_d   = load_len;
                    idx_d   = '0;
                    clr     = 1'b1;
                    stall_d = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
            LD_RECV: if (word_valid) begin
                state_d = LD_WRITE;
                we_d    = 1'b1;
                waddr_d = idx_q;
                wdata_d = word;
            end
            LD_WRITE: begin
                state_d   = last ? LD_FINISH : LD_RECV;
                idx_d     = last ? idx_q : idx_q + ADDR_W'(1);
                restart_d = last;
                stall_d   = last ? 1'b0 : stall_q;
            end
            default: state_d = LD_IDLE;
        endcase
        busy_d = state_d != LD_IDLE;
    end

    // The core stays stalled out of reset: no program is trusted until a load completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LD_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            stall_q   <= 1'b1;
            restart_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            stall_q   <= stall_d;
            restart_q <= restart_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign mem_we     = we_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign cpu_stall  = stall_q;
    assign pc_restart = restart_q;
    assign busy       = busy_q;
    assign err        = err_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed scenarios for the boot loader with a
// write-capturing memory model and hand-computed expected words.
module tb_imem_boot_loader;
    import mips_pkg::*;
    logic        clk = 0, rst_n = 0, start = 0, byte_valid = 0;
    logic [5:0]  load_len = '0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_we, cpu_stall, pc_restart, busy, err;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] wmem [IMEM_DEPTH];
    int checks = 0, errors = 0, cyc = 0, we_cnt = 0, restart_cnt = 0, restart_cyc = 0;
    logic stall_at_restart = 1'b1;

    imem_boot_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_stall(cpu_stall), .pc_restart(pc_restart), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (mem_we) begin
            wmem[mem_waddr] = mem_wdata;
            we_cnt++;
        end
        if (pc_restart) begin
            restart_cnt++;
            restart_cyc = cyc;
            stall_at_restart = cpu_stall;
        end
    end

    task automatic do_start(input logic [5:0] len, output int c0);
        c0 = cyc;
        start = 1;
        load_len = len;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic hs;
        int n = 0;
        byte_valid = 1;
        byte_data = b;
        do begin
            hs = byte_ready;
            @(negedge clk);
            n++;
        end while (!hs && n < 100);
        if (!hs) begin
            checks++; errors++;
            $display("FAIL byte_timeout: byte_ready got 0 expected 1 within 100 cycles");
        end
        byte_valid = 0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int b = 3; b >= 0; b--) begin
            send_byte(w[8*b +: 8]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic wait_restart();
        int n = 0;
        while (!pc_restart && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pc_restart) begin
            checks++; errors++;
            $display("FAIL restart_timeout: pc_restart got 0 expected 1 within 200 cycles");
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (cpu_stall !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0 || mem_we !== 1'b0 || pc_restart !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: stall/busy/ready/we/restart/err got %b%b%b%b%b%b expected 100000",
                         cpu_stall, busy, byte_ready, mem_we, pc_restart, err);
            end
        end
        checks++;
        if (we_cnt !== 0) begin errors++; $display("FAIL reset_no_write: writes got %0d expected 0", we_cnt); end
    endtask

    task automatic test_illegal_len();
        int c0;
        do_start(6'd0, c0);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || cpu_stall !== 1'b1) begin
            errors++; $display("FAIL len0: err/busy/stall got %b%b%b expected 101", err, busy, cpu_stall);
        end
        do_start(6'd33, c0);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || cpu_stall !== 1'b1 || byte_ready !== 1'b0) begin
            errors++; $display("FAIL len33: err/busy/stall/ready got %b%b%b%b expected 1010", err, busy, cpu_stall, byte_ready);
        end
        do_start(6'd1, c0);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL err_clear: err/busy got %b%b expected 01", err, busy);
        end
        send_word(32'hdeadbeef, 0);
        wait_restart();
        checks++;
        if (wmem[0] !== 32'hdeadbeef || we_cnt !== 1) begin
            errors++; $display("FAIL len1_load: word0 got %h writes %0d expected deadbeef writes 1", wmem[0], we_cnt);
        end
    endtask

    task automatic test_load3();
        int c0, w0 = we_cnt, r0 = restart_cnt;
        do_start(6'd3, c0);
        checks++;
        if (cpu_stall !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL load3_start: stall/busy got %b%b expected 11", cpu_stall, busy);
        end
        send_word(32'h2008000a, 0);
        send_word(32'h20090005, 0);
        send_word(32'h01095020, 0);
        wait_restart();
        checks++;
        if (wmem[0] !== 32'h2008000a || wmem[1] !== 32'h20090005 || wmem[2] !== 32'h01095020) begin
            errors++; $display("FAIL load3_words: got %h %h %h expected 2008000a 20090005 01095020", wmem[0], wmem[1], wmem[2]);
        end
        checks++;
        if (we_cnt - w0 !== 3) begin errors++; $display("FAIL load3_wecnt: got %0d expected 3", we_cnt - w0); end
        checks++;
        if (restart_cyc - c0 !== 16 || restart_cnt - r0 !== 1) begin
            errors++; $display("FAIL load3_latency: restart at %0d count %0d expected 16 count 1", restart_cyc - c0, restart_cnt - r0);
        end
        checks++;
        if (stall_at_restart !== 1'b0 || cpu_stall !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL load3_release: stall@restart/stall/busy got %b%b%b expected 000", stall_at_restart, cpu_stall, busy);
        end
    endtask

    task automatic test_toggle();
        int c0, w0 = we_cnt;
        do_start(6'd2, c0);
        send_word(32'h8c0a0004, 1);
        send_word(32'hac0b0008, 1);
        wait_restart();
        checks++;
        if (wmem[0] !== 32'h8c0a0004 || wmem[1] !== 32'hac0b0008 || we_cnt - w0 !== 2) begin
            errors++; $display("FAIL toggle_words: got %h %h writes %0d expected 8c0a0004 ac0b0008 writes 2", wmem[0], wmem[1], we_cnt - w0);
        end
        checks++;
        if (wmem[2] !== 32'h01095020) begin
            errors++; $display("FAIL toggle_untouched: word2 got %h expected 01095020", wmem[2]);
        end
    endtask

    task automatic test_restart_ignored();
        int c0, w0 = we_cnt, r0 = restart_cnt;
        do_start(6'd2, c0);
        send_word(32'h11112222, 0);
        start = 1;
        load_len = 6'd5;
        @(negedge clk);
        start = 0;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || cpu_stall !== 1'b1) begin
            errors++; $display("FAIL midstart_state: busy/err/stall got %b%b%b expected 101", busy, err, cpu_stall);
        end
        send_word(32'h33334444, 0);
        wait_restart();
        checks++;
        if (we_cnt - w0 !== 2 || restart_cnt - r0 !== 1 || busy !== 1'b0) begin
            errors++; $display("FAIL midstart_len: writes %0d restarts %0d busy %b expected 2 1 0", we_cnt - w0, restart_cnt - r0, busy);
        end
        checks++;
        if (wmem[0] !== 32'h11112222 || wmem[1] !== 32'h33334444) begin
            errors++; $display("FAIL midstart_words: got %h %h expected 11112222 33334444", wmem[0], wmem[1]);
        end
    endtask

    task automatic test_reset_midload();
        int c0;
        logic [31:0] w;
        do_start(6'd4, c0);
        send_word(32'hcafe0000, 0);
        send_word(32'hcafe0001, 0);
        @(negedge clk);
        checks++;
        if (wmem[1] !== 32'hcafe0001 || busy !== 1'b1) begin
            errors++; $display("FAIL midload_progress: word1 got %h busy %b expected cafe0001 1", wmem[1], busy);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (byte_ready !== 1'b0 || busy !== 1'b0 || cpu_stall !== 1'b1 || mem_we !== 1'b0 || pc_restart !== 1'b0 ||
            err !== 1'b0 || mem_waddr !== 5'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL async_reset: ready/busy/stall/we/restart/err got %b%b%b%b%b%b addr %h data %h expected 001000 addr 00 data 00000000",
                               byte_ready, busy, cpu_stall, mem_we, pc_restart, err, mem_waddr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < IMEM_DEPTH; i++) wmem[i] = 'x;
        we_cnt = 0;
        do_start(6'd32, c0);
        for (int i = 0; i < IMEM_DEPTH; i++) send_word(32'h24000000 + i * 32'h00010101, 0);
        wait_restart();
        checks++;
        if (we_cnt !== 32 || cpu_stall !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL full_load: writes %0d stall %b busy %b expected 32 0 0", we_cnt, cpu_stall, busy);
        end
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            w = 32'h24000000 + i * 32'h00010101;
            checks++;
            if (wmem[i] !== w) begin errors++; $display("FAIL full_word%0d: got %h expected %h", i, wmem[i], w); end
        end
        checks++;
        if (restart_cyc - c0 !== 5 * 32 + 1) begin
            errors++; $display("FAIL full_latency: got %0d expected 161", restart_cyc - c0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1;
        test_reset();
        test_illegal_len();
        test_load3();
        test_toggle();
        test_restart_ignored();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
